// File: rtl/interrupt_reset_sequencer.sv
// Reset-vector load and hardware-interrupt entry sequencer.
// Stalls fetch, drains the pipe, pushes the return PC and flags, then loads the
// interrupt vector. It owns the memory port only while a sequence is running.
module interrupt_reset_sequencer #(
    parameter int unsigned       DATA_W         = 16,
    parameter int unsigned       FLAG_W         = 3,
    parameter logic [DATA_W-1:0] RESET_VEC_ADDR = DATA_W'(16'h0000),
    parameter logic [DATA_W-1:0] INT_VEC_ADDR   = DATA_W'(16'h0001),
    parameter int unsigned       DRAIN_CYCLES   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              int_req,
    input  logic              pipe_busy_mem,
    input  logic              branch_in_flight,
    input  logic [DATA_W-1:0] pc_next,
    input  logic [FLAG_W-1:0] flags_in,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              fetch_stall,
    output logic              flush,
    output logic              mem_sel,
    output logic              ctl_read,
    output logic [DATA_W-1:0] ctl_addr,
    output logic              ctl_push,
    output logic [DATA_W-1:0] ctl_wdata,
    output logic              pc_load,
    output logic [DATA_W-1:0] pc_load_value,
    output logic              int_ack
);

    // A zero drain count would never satisfy the counter==1 exit test.
    localparam int unsigned DRAIN_EFF = (DRAIN_CYCLES == 0) ? 1 : DRAIN_CYCLES;
    localparam int unsigned CNT_W     = $clog2(DRAIN_EFF + 1);

    localparam logic [2:0] RST_RD     = 3'd0;
    localparam logic [2:0] RST_LD     = 3'd1;
    localparam logic [2:0] IDLE       = 3'd2;
    localparam logic [2:0] DRAIN      = 3'd3;
    localparam logic [2:0] PUSH_PC    = 3'd4;
    localparam logic [2:0] PUSH_FLAGS = 3'd5;
    localparam logic [2:0] VEC_RD     = 3'd6;
    localparam logic [2:0] VEC_LD     = 3'd7;

    logic [2:0]        state,       state_nxt;
    logic              pending,     pending_nxt;
    logic [CNT_W-1:0]  cnt,         cnt_nxt;
    logic [DATA_W-1:0] ret_pc,      ret_pc_nxt;
    logic [FLAG_W-1:0] saved_flags, saved_flags_nxt;

    // State and context registers; synchronous reset restarts the reset-vector load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RST_RD;
            pending     <= 1'b0;
            cnt         <= '0;
            ret_pc      <= '0;
            saved_flags <= '0;
        end else begin
            state       <= state_nxt;
            pending     <= pending_nxt;
            cnt         <= cnt_nxt;
            ret_pc      <= ret_pc_nxt;
            saved_flags <= saved_flags_nxt;
        end
    end

    // Next-state logic and Moore output decode; outputs are forced low during reset.
    always_comb begin
        state_nxt       = state;
        pending_nxt     = pending;
        cnt_nxt         = cnt;
        ret_pc_nxt      = ret_pc;
        saved_flags_nxt = saved_flags;
        fetch_stall     = 1'b0;
        flush           = 1'b0;
        mem_sel         = 1'b0;
        ctl_read        = 1'b0;
        ctl_addr        = '0;
        ctl_push        = 1'b0;
        ctl_wdata       = '0;
        pc_load         = 1'b0;
        pc_load_value   = '0;
        int_ack         = 1'b0;

        if (state != IDLE) begin
            fetch_stall = 1'b1;
            flush       = 1'b1;
        end

        case (state)
            RST_RD: begin
                mem_sel   = 1'b1;
                ctl_read  = 1'b1;
                ctl_addr  = RESET_VEC_ADDR;
                state_nxt = RST_LD;
            end
            RST_LD: begin
                pc_load       = 1'b1;
                pc_load_value = mem_rdata;
                state_nxt     = IDLE;
            end
            IDLE: begin
                if (int_req || pending) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = CNT_W'(DRAIN_EFF);
                end
            end
            DRAIN: begin
                if (cnt > CNT_W'(1)) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
                if (cnt == CNT_W'(1) && !pipe_busy_mem && !branch_in_flight) begin
                    state_nxt       = PUSH_PC;
                    ret_pc_nxt      = pc_next;
                    saved_flags_nxt = flags_in;
                    pending_nxt     = 1'b0;
                end
            end
            PUSH_PC: begin
                mem_sel   = 1'b1;
                ctl_push  = 1'b1;
                ctl_wdata = ret_pc;
                state_nxt = PUSH_FLAGS;
            end
            PUSH_FLAGS: begin
                mem_sel   = 1'b1;
                ctl_push  = 1'b1;
                ctl_wdata = DATA_W'(saved_flags);
                state_nxt = VEC_RD;
            end
            VEC_RD: begin
                mem_sel   = 1'b1;
                ctl_read  = 1'b1;
                ctl_addr  = INT_VEC_ADDR;
                state_nxt = VEC_LD;
            end
            VEC_LD: begin
                pc_load       = 1'b1;
                pc_load_value = mem_rdata;
                int_ack       = 1'b1;
                state_nxt     = IDLE;
            end
            default: begin
                state_nxt = RST_RD;
            end
        endcase

        // A request seen in the exit cycle of DRAIN stays pending so it is not lost.
        if (int_req && state != RST_RD && state != RST_LD) begin
            pending_nxt = 1'b1;
        end

        if (rst) begin
            fetch_stall   = 1'b0;
            flush         = 1'b0;
            mem_sel       = 1'b0;
            ctl_read      = 1'b0;
            ctl_addr      = '0;
            ctl_push      = 1'b0;
            ctl_wdata     = '0;
            pc_load       = 1'b0;
            pc_load_value = '0;
            int_ack       = 1'b0;
        end
    end

endmodule

// File: tb/tb_interrupt_reset_sequencer.sv
// Directed bench for interrupt_reset_sequencer with a small read-latency memory model.
module tb_interrupt_reset_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        int_req;
    logic        pipe_busy_mem;
    logic        branch_in_flight;
    logic [15:0] pc_next;
    logic [2:0]  flags_in;
    logic [15:0] mem_rdata;
    logic        fetch_stall;
    logic        flush;
    logic        mem_sel;
    logic        ctl_read;
    logic [15:0] ctl_addr;
    logic        ctl_push;
    logic [15:0] ctl_wdata;
    logic        pc_load;
    logic [15:0] pc_load_value;
    logic        int_ack;

    logic [15:0] mem [0:3];
    int checks = 0;
    int errors = 0;

    interrupt_reset_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .int_req          (int_req),
        .pipe_busy_mem    (pipe_busy_mem),
        .branch_in_flight (branch_in_flight),
        .pc_next          (pc_next),
        .flags_in         (flags_in),
        .mem_rdata        (mem_rdata),
        .fetch_stall      (fetch_stall),
        .flush            (flush),
        .mem_sel          (mem_sel),
        .ctl_read         (ctl_read),
        .ctl_addr         (ctl_addr),
        .ctl_push         (ctl_push),
        .ctl_wdata        (ctl_wdata),
        .pc_load          (pc_load),
        .pc_load_value    (pc_load_value),
        .int_ack          (int_ack)
    );

    always #5 clk = ~clk;

    // Read data appears the cycle after ctl_read.
    always @(posedge clk) begin
        if (ctl_read) mem_rdata <= mem[ctl_addr[1:0]];
    end

    function automatic logic [63:0] all_outs();
        return {9'd0, fetch_stall, flush, mem_sel, ctl_read, ctl_push, pc_load, int_ack,
                ctl_addr, ctl_wdata, pc_load_value};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic chk_drain(input string tag);
        chk({tag, "_stall"}, 64'(fetch_stall), 64'd1);
        chk({tag, "_memsel"}, 64'(mem_sel), 64'd0);
    endtask

    task automatic chk_push(input string tag, input logic [15:0] d);
        chk({tag, "_push"}, 64'(ctl_push), 64'd1);
        chk({tag, "_wdata"}, 64'(ctl_wdata), 64'(d));
    endtask

    task automatic chk_ack(input string tag, input logic [15:0] v);
        chk({tag, "_ack"}, 64'(int_ack), 64'd1);
        chk({tag, "_pcload"}, 64'(pc_load), 64'd1);
        chk({tag, "_pcval"}, 64'(pc_load_value), 64'(v));
    endtask

    initial begin
        mem[0] = 16'h0040;
        mem[1] = 16'h0200;
        mem[2] = 16'h0000;
        mem[3] = 16'h0000;
        mem_rdata        = 16'h0000;
        rst              = 1'b1;
        int_req          = 1'b0;
        pipe_busy_mem    = 1'b0;
        branch_in_flight = 1'b0;
        pc_next          = 16'h0123;
        flags_in         = 3'b101;

        // Reset vector load
        cyc(); cyc(); settle();
        chk("rst_outs_zero", all_outs(), 64'd0);
        rst = 1'b0; settle();
        chk("rst_rd_read", 64'({mem_sel, ctl_read, fetch_stall, flush}), 64'hF);
        chk("rst_rd_addr", 64'(ctl_addr), 64'h0000);
        cyc(); settle();
        chk("rst_ld_pcload", 64'(pc_load), 64'd1);
        chk("rst_ld_value", 64'(pc_load_value), 64'h0040);
        chk("rst_ld_ack", 64'(int_ack), 64'd0);
        cyc(); settle();
        chk("idle_outs_zero", all_outs(), 64'd0);

        // Basic interrupt: request at t
        int_req = 1'b1; settle();
        chk("basic_t_idle", 64'(fetch_stall), 64'd0);
        cyc(); int_req = 1'b0; settle();
        chk_drain("basic_t1");
        cycles(2); settle();
        chk_drain("basic_t3");
        cyc(); settle();
        chk_push("basic_t4", 16'h0123);
        cyc(); settle();
        chk_push("basic_t5", 16'h0005);
        cyc(); settle();
        chk("basic_t6_read", 64'({mem_sel, ctl_read, ctl_push}), 64'h6);
        chk("basic_t6_addr", 64'(ctl_addr), 64'h0001);
        cyc(); settle();
        chk_ack("basic_t7", 16'h0200);
        cyc(); settle();
        chk("basic_t8_idle", all_outs(), 64'd0);

        // Busy extension: pipe_busy_mem high t+1..t+5
        pc_next = 16'h0111;
        cyc(); int_req = 1'b1;
        cyc(); int_req = 1'b0; pipe_busy_mem = 1'b1;
        cycles(4); settle();
        chk_drain("busy_t5");
        cyc(); pipe_busy_mem = 1'b0; pc_next = 16'h0456; settle();
        chk_drain("busy_t6");
        cyc(); pc_next = 16'h0999; settle();
        chk_push("busy_t7", 16'h0456);
        cyc(); settle();
        chk_push("busy_t8", 16'h0005);
        cyc(); settle();
        chk("busy_t9_ack", 64'(int_ack), 64'd0);
        cyc(); settle();
        chk_ack("busy_t10", 16'h0200);

        // Branch during drain: pc_next redirects to 0x0300 at t+2
        pc_next = 16'h0150; flags_in = 3'b010;
        cyc(); int_req = 1'b1;
        cyc(); int_req = 1'b0; branch_in_flight = 1'b1;
        cyc(); pc_next = 16'h0300;
        cyc(); branch_in_flight = 1'b0; settle();
        chk_drain("br_t3");
        cyc(); settle();
        chk_push("br_t4", 16'h0300);
        cyc(); settle();
        chk_push("br_t5", 16'h0002);
        cycles(2); settle();
        chk_ack("br_t7", 16'h0200);

        // Request during service is held and serviced after return to IDLE
        pc_next = 16'h0123; flags_in = 3'b101;
        cyc(); int_req = 1'b1;
        cyc(); int_req = 1'b0;
        cycles(4); int_req = 1'b1;
        cyc(); int_req = 1'b0;
        cyc(); settle();
        chk_ack("svc_t7", 16'h0200);
        cyc(); settle();
        chk("svc_t8_idle", 64'(fetch_stall), 64'd0);
        cyc(); settle();
        chk_drain("svc_t9");
        cycles(3); settle();
        chk_push("svc_t12", 16'h0123);
        cycles(2); settle();
        chk("svc_t14_ack", 64'(int_ack), 64'd0);
        cyc(); settle();
        chk_ack("svc_t15", 16'h0200);

        // Reset mid-sequence: pending set at t+4, rst at t+5, requests during reset states ignored
        cyc(); int_req = 1'b1;
        cyc(); int_req = 1'b0;
        cycles(3); int_req = 1'b1;
        cyc(); int_req = 1'b0; rst = 1'b1; settle();
        chk("midrst_t5_zero", all_outs(), 64'd0);
        cyc(); rst = 1'b0; int_req = 1'b1; settle();
        chk("midrst_t6_read", 64'({ctl_read, ctl_push}), 64'h2);
        chk("midrst_t6_addr", 64'(ctl_addr), 64'h0000);
        cyc(); settle();
        chk("midrst_t7_pcval", 64'(pc_load_value), 64'h0040);
        chk("midrst_t7_ack", 64'(int_ack), 64'd0);
        cyc(); int_req = 1'b0; settle();
        chk("midrst_t8_idle", all_outs(), 64'd0);
        cyc(); settle();
        chk("midrst_t9_idle", all_outs(), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/interrupt_reset_sequencer.md
Name: interrupt_reset_sequencer

Overview:
- Sequences the 5-stage pipeline through two events: the reset-vector load and hardware-interrupt entry.
- On reset it reads the start PC from data memory.
- On an interrupt it stalls fetch, drains in-flight instructions, pushes the return PC and flags via the memory stage's stack path, then loads the interrupt vector into PC.
- It sits beside fetch_stage and memory_stage and takes over the memory port only while sequencing.

Parameters:
DATA_W, 16, datapath/address width
FLAG_W, 3, flag register width {C,N,Z}
RESET_VEC_ADDR, 16'h0000, memory word holding the reset PC
INT_VEC_ADDR, 16'h0001, memory word holding the ISR address
DRAIN_CYCLES, 3, minimum cycles for ID/EX/MEM to retire

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
int_req  in  1  external interrupt request; sampled each cycle
pipe_busy_mem  in  1  memory stage currently holds a load/store/push/pop
branch_in_flight  in  1  jump/call/ret in EX or MEM not yet resolved
pc_next  in  DATA_W  PC of next instruction to fetch (return address)
flags_in  in  FLAG_W  current flag register
mem_rdata  in  DATA_W  memory_stage read data; valid the cycle after ctl_read
fetch_stall  out  1  hold PC, no new fetch
flush  out  1  clear IF/ID (inject NOP)
mem_sel  out  1  sequencer owns memory port
ctl_read  out  1  read at ctl_addr
ctl_addr  out  DATA_W  absolute read address
ctl_push  out  1  stack push of ctl_wdata (SP decrement by memory stage)
ctl_wdata  out  DATA_W  push data
pc_load  out  1  force PC to pc_load_value (priority over pc_write)
pc_load_value  out  DATA_W  new PC
int_ack  out  1  one-cycle pulse when ISR vector is loaded

Behaviour:
- States: RST_RD, RST_LD, IDLE, DRAIN, PUSH_PC, PUSH_FLAGS, VEC_RD, VEC_LD.
- While rst=1: state<=RST_RD; pending, counter, ret_pc, saved_flags cleared.
- Outputs while rst=1 and in IDLE: all 0. Outputs are Moore (decoded from state and registers).
- fetch_stall=1 and flush=1 in every state except IDLE.
- RST_RD: mem_sel=1, ctl_read=1, ctl_addr=RESET_VEC_ADDR. Next state RST_LD.
- RST_LD: pc_load=1, pc_load_value=mem_rdata. Next state IDLE.
- pending flag:
  - Set by int_req=1 in any state other than RST_RD/RST_LD.
  - Cleared on the DRAIN->PUSH_PC transition.
  - A request arriving after that clear is held and serviced after return to IDLE.
  - Requests during reset states are ignored.
- IDLE: if int_req|pending, next state DRAIN and counter<=DRAIN_CYCLES.
- DRAIN:
  - Counter decrements, saturating at 1.
  - Exit when counter==1 and pipe_busy_mem=0 and branch_in_flight=0. DRAIN therefore lasts at least DRAIN_CYCLES cycles and extends while either busy input is high.
  - In the exit cycle, ret_pc<=pc_next and saved_flags<=flags_in. Branch redirects during DRAIN still update PC, so the captured pc_next is the resolved target.
- PUSH_PC: mem_sel=1, ctl_push=1, ctl_wdata=ret_pc.
- PUSH_FLAGS: mem_sel=1, ctl_push=1, ctl_wdata=zero-extended saved_flags.
- VEC_RD: mem_sel=1, ctl_read=1, ctl_addr=INT_VEC_ADDR.
- VEC_LD: pc_load=1, pc_load_value=mem_rdata, int_ack=1. Next state IDLE.
- No nesting: interrupts are masked from DRAIN through VEC_LD; only pending records them.
- Latency: int_req high in IDLE cycle t (no busy) gives DRAIN t+1..t+3, PUSH_PC t+4, PUSH_FLAGS t+5, VEC_RD t+6, VEC_LD t+7 (pc_load, int_ack).
- rst mid-sequence: abort immediately, no partial push completion; restart at RST_RD.
- counter width: $clog2(DRAIN_CYCLES+1). DRAIN_CYCLES=0 is treated as 1.

Test Plan:
- Reset vector load: M[0]=16'h0040, rst high 2 cycles then low at cycle 0 -> ctl_read=1, ctl_addr=0 at cycle 0; pc_load=1, value 16'h0040 at cycle 1; IDLE with all outputs 0 at cycle 2.
- Basic interrupt: pc_next=16'h0123, flags=3'b101, M[1]=16'h0200, int_req pulse at cycle t -> pushes 16'h0123 at t+4 and 16'h0005 at t+5; pc_load=16'h0200 and int_ack at t+7.
- Busy extension: pipe_busy_mem high t+1..t+5 -> PUSH_PC at t+7; pc_next captured at t+6; int_ack at t+10.
- Branch during drain: branch_in_flight high t+1..t+2, pc_next changes to 16'h0300 at t+2 -> pushed return PC is 16'h0300.
- Request during service: int_req at t+5 -> after VEC_LD at t+7, IDLE at t+8, DRAIN at t+9, second int_ack at t+15.
- Reset mid-sequence: rst at t+5 (PUSH_FLAGS) -> next cycle RST_RD, ctl_push=0, pending cleared, no int_ack.
